agc_window_ctrl: RTL and testbench
==================================

AGC_WINDOW_CTRL -- requirements
Module: agc_window_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 3, giving an accumulation window of 2^WIN_LOG2 = 8 samples.
REQ-002 SHALL have parameter TGT_HI, default 20000, the upper window-sum threshold.
REQ-003 SHALL have parameter TGT_LO, default 12000, the lower window-sum threshold.
REQ-004 SHALL have parameter GAIN_MAX, default 63, the gain ceiling; parameter GAIN_INIT, default 32, the post-reset gain.
REQ-005 SHALL have port i_clk, input, 1 bit: clock, all logic on rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port i_en, input, 1 bit: run enable.
REQ-008 SHALL have port i_sample_vld, input, 1 bit: sample qualifier.
REQ-009 SHALL have port i_sample, input, 12 bits: unsigned magnitude, Q1.11.
REQ-010 SHALL have port o_sum, output, 15 bits: completed window sum, Q1.14 scaling.
REQ-011 SHALL have port o_sum_vld, output, 1 bit; i_sum_rdy, input, 1 bit: valid/ready handshake for o_sum.
REQ-012 SHALL have port o_ovr, output, 1 bit: one-cycle pulse when a window result is dropped.
REQ-013 SHALL have port o_gain, output, 6 bits: current gain code.
REQ-014 SHALL have port o_busy, output, 1 bit: high while in RUN.

Function
REQ-015 SHALL implement FSM states IDLE and RUN: IDLE->RUN when i_en=1; RUN->IDLE when i_en=0.
REQ-016 SHALL, in RUN, add i_sample to a 15-bit accumulator and increment a WIN_LOG2-bit counter each cycle i_sample_vld=1; samples in IDLE are ignored.
REQ-017 SHALL use no saturation in the sum; 8*4095=32760 fits 15 bits.
REQ-018 SHALL, on the cycle the 8th valid sample is accepted, treat the window as complete, including that sample.
REQ-019 SHALL, on window completion, clear the accumulator and counter so the next valid sample starts a new window with no gap cycle.
REQ-020 SHALL, on completion with the output buffer empty or being accepted that cycle, load o_sum and assert o_sum_vld from the next cycle.
REQ-021 SHALL hold o_sum and o_sum_vld stable until i_sum_rdy=1 while o_sum_vld=1; the buffer is freed on that cycle.
REQ-022 SHALL, on completion with the buffer full and not being accepted, discard the new sum, keep the old one, and pulse o_ovr for one cycle.
REQ-023 SHALL, one cycle after every completion (including dropped ones), set o_gain to o_gain-1 if sum > TGT_HI, o_gain+1 if sum < TGT_LO, otherwise unchanged.
REQ-024 SHALL saturate o_gain at 0 and GAIN_MAX; equality with either threshold means no change.
REQ-025 SHALL, when i_en falls mid-window, discard the partial sum and clear the counter; a pending o_sum_vld remains until accepted; o_gain is retained.
REQ-026 SHALL, when i_en=0 coincides with the completing sample, abort the window: no output and no gain update.
REQ-027 SHALL drive o_busy=1 exactly while the state is RUN.

Reset
REQ-028 SHALL, on i_rst low, immediately force IDLE, accumulator=0, counter=0, o_sum=0, o_sum_vld=0, o_ovr=0, o_busy=0, o_gain=GAIN_INIT.
REQ-029 SHALL, when reset occurs mid-window or with a pending result, lose both without any o_ovr pulse.

Structure
REQ-030 SHALL place the FSM state encoding, sample/sum/gain widths and default thresholds in shared package agc_pkg.
REQ-031 SHALL implement the accumulator and counter as sub-module agc_win_accum (inputs clr, vld, sample; outputs sum, done); the FSM, output buffer and gain logic stay in the top level.

Verification
REQ-032 SHALL check reset: after release, o_gain=32, o_sum=0, o_sum_vld=0, o_busy=0.
REQ-033 SHALL check nominal window: i_en=1, 8 x 0x800 back-to-back, i_sum_rdy=1 -> o_sum=16384 with o_sum_vld the cycle after the 8th sample, o_gain stays 32.
REQ-034 SHALL check gain saturation: repeated windows of 8 x 4095 -> o_sum=32760 each, o_gain decrements one per window to 0 and holds; windows of 8 x 0 raise it to 63 and hold.
REQ-035 SHALL check backpressure: i_sum_rdy=0, 16 samples of 0x800 -> o_sum holds 16384, one o_ovr pulse at the 16th sample; asserting i_sum_rdy frees the buffer.
REQ-036 SHALL check abort: 5 valid samples, then i_en=0 for 1 cycle, then 8 samples of 100 -> a single o_sum=800 and o_gain increments by 1.
REQ-037 SHALL check mid-window reset: i_rst low after 4 samples -> all outputs at reset values; the next 8 samples produce a clean sum.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types, widths and default thresholds for the AGC window controller.
package agc_pkg;

  localparam int unsigned SAMPLE_W    = 12;    // Q1.11 unsigned magnitude
  localparam int unsigned SUM_W       = 15;    // Q1.14 window sum (8 x 4095 fits)
  localparam int unsigned GAIN_W      = 6;
  localparam int unsigned WIN_LOG2_DEF = 3;
  localparam int unsigned TGT_HI_DEF  = 20000;
  localparam int unsigned TGT_LO_DEF  = 12000;
  localparam int unsigned GAIN_MAX_DEF = 63;
  localparam int unsigned GAIN_INIT_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One gain step from a completed window sum; thresholds are exclusive, saturates at 0/gmax.
  function automatic logic [GAIN_W-1:0] gain_step(
    input logic [GAIN_W-1:0] gain,
    input logic [SUM_W-1:0]  sum,
    input int unsigned       hi,
    input int unsigned       lo,
    input int unsigned       gmax
  );
    logic [GAIN_W-1:0] g;
    g = gain;
    if (32'(sum) > hi) begin
      if (gain != '0) g = gain - GAIN_W'(1);
    end else if (32'(sum) < lo) begin
      if (32'(gain) < gmax) g = gain + GAIN_W'(1);
    end
    return g;
  endfunction

endpackage

// File: rtl/agc_win_accum.sv
// Window accumulator: sums 2^WIN_LOG2 qualified samples; sum/done are combinational
// so the completing sample is included in the same cycle it is accepted.
module agc_win_accum
  import agc_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                clr,
  input  logic                vld,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SUM_W-1:0]    sum,
  output logic                done
);

  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;

  // Running sum, completion detect, and restart-on-completion with no gap cycle.
  always_comb begin
    sum   = acc_q + SUM_W'(sample);
    done  = vld && (cnt_q == {WIN_LOG2{1'b1}});
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (vld) begin
      if (done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + WIN_LOG2'(1);
      end
    end
  end

  // Accumulator and counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/agc_window_ctrl.sv
// AGC window controller: IDLE/RUN FSM, one-deep result buffer with drop detect,
// and a saturating gain code stepped once per completed window.
module agc_window_ctrl
  import agc_pkg::*;
#(
  parameter int unsigned WIN_LOG2  = WIN_LOG2_DEF,
  parameter int unsigned TGT_HI    = TGT_HI_DEF,
  parameter int unsigned TGT_LO    = TGT_LO_DEF,
  parameter int unsigned GAIN_MAX  = GAIN_MAX_DEF,
  parameter int unsigned GAIN_INIT = GAIN_INIT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_sample_vld,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [SUM_W-1:0]    o_sum,
  output logic                o_sum_vld,
  input  logic                i_sum_rdy,
  output logic                o_ovr,
  output logic [GAIN_W-1:0]   o_gain,
  output logic                o_busy
);

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               sum_vld_q, sum_vld_d;
  logic               ovr_q, ovr_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               busy_q, busy_d;

  logic               acc_clr;
  logic               acc_vld;
  logic [SUM_W-1:0]   win_sum;
  logic               win_done;
  logic               take;

  // Samples only count in RUN with enable still high; dropping enable aborts the window.
  assign acc_clr = (state_q != ST_RUN) || !i_en;
  assign acc_vld = (state_q == ST_RUN) && i_en && i_sample_vld;

  agc_win_accum #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_accum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .clr    (acc_clr),
    .vld    (acc_vld),
    .sample (i_sample),
    .sum    (win_sum),
    .done   (win_done)
  );

  // Next state, result buffer, overrun pulse and gain step.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    sum_vld_d = sum_vld_q;
    ovr_d     = 1'b0;
    gain_d    = gain_q;
    take      = sum_vld_q && i_sum_rdy;

    case (state_q)
      ST_IDLE: if (i_en)  state_d = ST_RUN;
      ST_RUN:  if (!i_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (take) sum_vld_d = 1'b0;

    if (win_done) begin
      if (!sum_vld_q || take) begin
        sum_d     = win_sum;
        sum_vld_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
      gain_d = gain_step(gain_q, win_sum, TGT_HI, TGT_LO, GAIN_MAX);
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      gain_q    <= GAIN_W'(GAIN_INIT);
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      ovr_q     <= ovr_d;
      gain_q    <= gain_d;
      busy_q    <= busy_d;
    end
  end

  assign o_sum     = sum_q;
  assign o_sum_vld = sum_vld_q;
  assign o_ovr     = ovr_q;
  assign o_gain    = gain_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_agc_window_ctrl.sv
// Directed bench for agc_window_ctrl: a vector table for the nominal window plus
// hand-written sequences for abort, backpressure, reset and gain saturation.
module tb_agc_window_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        svld;
  logic [11:0] sample;
  logic [14:0] sum;
  logic        sum_vld;
  logic        sum_rdy;
  logic        ovr;
  logic [5:0]  gain;
  logic        busy;

  int errors = 0;
  int checks = 0;

  agc_window_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_sample_vld (svld),
    .i_sample     (sample),
    .o_sum        (sum),
    .o_sum_vld    (sum_vld),
    .i_sum_rdy    (sum_rdy),
    .o_ovr        (ovr),
    .o_gain       (gain),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [11:0] smp;
    logic        rdy;
    logic [14:0] e_sum;
    logic        e_vld;
    logic        e_ovr;
    logic [5:0]  e_gain;
    logic        e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [11:0] s, input logic r);
    en = e; svld = v; sample = s; sum_rdy = r;
  endtask

  task automatic chk_all(input string tag, input logic [14:0] es, input logic ev,
                         input logic eo, input logic [5:0] eg, input logic eb);
    chk({tag, ".sum"},  32'(sum),     32'(es));
    chk({tag, ".vld"},  32'(sum_vld), 32'(ev));
    chk({tag, ".ovr"},  32'(ovr),     32'(eo));
    chk({tag, ".gain"}, 32'(gain),    32'(eg));
    chk({tag, ".busy"}, 32'(busy),    32'(eb));
  endtask

  int exp_gain;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 12'd0, 1'b0);

    // Nominal window: enable cycle, 8 x 0x800, then one idle cycle draining the buffer.
    vecs[0] = '{1'b1, 1'b0, 12'h000, 1'b1, 15'd0, 1'b0, 1'b0, 6'd32, 1'b1};
    for (int i = 1; i <= 7; i++)
      vecs[i] = '{1'b1, 1'b1, 12'h800, 1'b1, 15'd0, 1'b0, 1'b0, 6'd32, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 12'h800, 1'b1, 15'd16384, 1'b1, 1'b0, 6'd32, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 12'h000, 1'b1, 15'd16384, 1'b0, 1'b0, 6'd32, 1'b1};

    // Reset state, both during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", 15'd0, 1'b0, 1'b0, 6'd32, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk_all("rst_rel", 15'd0, 1'b0, 1'b0, 6'd32, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].en, vecs[i].vld, vecs[i].smp, vecs[i].rdy);
      tick();
      chk_all($sformatf("nom[%0d]", i), vecs[i].e_sum, vecs[i].e_vld,
              vecs[i].e_ovr, vecs[i].e_gain, vecs[i].e_busy);
    end

    // Enable dropping together with the completing sample aborts the window.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 12'd100, 1'b1);
      tick();
      chk("late_abort.pre_vld", 32'(sum_vld), 32'd0);
    end
    drive(1'b0, 1'b1, 12'd100, 1'b1);
    tick();
    chk_all("late_abort", 15'd16384, 1'b0, 1'b0, 6'd32, 1'b0);
    drive(1'b1, 1'b0, 12'd0, 1'b1);
    tick();
    chk("late_abort.rerun", 32'(busy), 32'd1);

    // Mid-window abort: 5 samples, enable low one cycle, then a clean 8 x 100 window.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 12'h800, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 12'd0, 1'b1);
    tick();
    chk_all("abort.idle", 15'd16384, 1'b0, 1'b0, 6'd32, 1'b0);
    drive(1'b1, 1'b0, 12'd0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 12'd100, 1'b1);
      tick();
      if (i < 7) chk("abort.early_vld", 32'(sum_vld), 32'd0);
    end
    chk_all("abort.done", 15'd800, 1'b1, 1'b0, 6'd33, 1'b1);
    drive(1'b1, 1'b0, 12'd0, 1'b1);
    tick();
    chk("abort.taken", 32'(sum_vld), 32'd0);

    // Backpressure: 16 samples with no ready; second result dropped with one o_ovr pulse.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 12'h800, 1'b0);
      tick();
      if (i == 7) chk_all("bp.first", 15'd16384, 1'b1, 1'b0, 6'd33, 1'b1);
      else if (i == 15) chk_all("bp.drop", 15'd16384, 1'b1, 1'b1, 6'd33, 1'b1);
      else chk("bp.no_ovr", 32'(ovr), 32'd0);
    end
    drive(1'b1, 1'b0, 12'd0, 1'b0);
    tick();
    chk_all("bp.hold", 15'd16384, 1'b1, 1'b0, 6'd33, 1'b1);
    drive(1'b1, 1'b0, 12'd0, 1'b1);
    tick();
    chk("bp.freed", 32'(sum_vld), 32'd0);

    // Reset with a pending result and a partial window: everything lost, no overrun.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 12'h400, 1'b0);
      tick();
    end
    chk_all("mrst.pending", 15'd8192, 1'b1, 1'b0, 6'd34, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 12'h800, 1'b0);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk_all("mrst.async", 15'd0, 1'b0, 1'b0, 6'd32, 1'b0);
    drive(1'b1, 1'b0, 12'd0, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    chk_all("mrst.rerun", 15'd0, 1'b0, 1'b0, 6'd32, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 12'h800, 1'b1);
      tick();
      if (i < 7) chk("mrst.early_vld", 32'(sum_vld), 32'd0);
    end
    chk_all("mrst.clean", 15'd16384, 1'b1, 1'b0, 6'd32, 1'b1);

    // Gain saturation: full-scale windows walk the gain to 0, silent ones to 63.
    exp_gain = 32;
    for (int w = 0; w < 34; w++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, 12'd4095, 1'b1);
        tick();
      end
      if (exp_gain > 0) exp_gain--;
      chk($sformatf("sat_lo[%0d].sum", w), 32'(sum), 32'd32760);
      chk($sformatf("sat_lo[%0d].gain", w), 32'(gain), 32'(exp_gain));
    end
    chk("sat_lo.floor", 32'(gain), 32'd0);
    for (int w = 0; w < 65; w++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, 12'd0, 1'b1);
        tick();
      end
      if (exp_gain < 63) exp_gain++;
      chk($sformatf("sat_hi[%0d].sum", w), 32'(sum), 32'd0);
      chk($sformatf("sat_hi[%0d].gain", w), 32'(gain), 32'(exp_gain));
    end
    chk("sat_hi.ceiling", 32'(gain), 32'd63);

    drive(1'b0, 1'b0, 12'd0, 1'b1);
    tick();
    chk("final.busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
